// File: rtl/exc_dispatch_pkg.sv
// rtl/exc_dispatch_pkg.sv - shared encodings for the MEM/WB exception dispatcher
// Holds the CP0 exception_type bit positions, the MEM-stage flag vector bit
// order, the dispatcher FSM state encoding and the wait-counter width helper.
package exc_dispatch_pkg;

  // Bit positions in the one-hot exception_type word sent to CP0
  localparam int EXC_FETCH_ADEL  = 31;
  localparam int EXC_RI          = 30;
  localparam int EXC_OV          = 29;
  localparam int EXC_BP          = 28;
  localparam int EXC_SYS         = 27;
  localparam int EXC_LOAD_ADEL   = 26;
  localparam int EXC_STORE_ADES  = 25;
  localparam int EXC_ERET        = 0;

  // Bit order of the MEM-stage exception flag vector (7 = highest priority)
  localparam int FLG_FETCH_ADEL  = 7;
  localparam int FLG_RI          = 6;
  localparam int FLG_OV          = 5;
  localparam int FLG_BP          = 4;
  localparam int FLG_SYS         = 3;
  localparam int FLG_LOAD_ADEL   = 2;
  localparam int FLG_STORE_ADES  = 1;
  localparam int FLG_ERET        = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_CP0 = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  // Wait counter width; never narrower than one bit
  function automatic int wait_cnt_width(input int wait_max);
    return (wait_max > 1) ? $clog2(wait_max) : 1;
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - priority encoder from MEM exception flags to CP0 cause
// Ports:
//   i_flags     in  8   MEM-stage exception flags (bit7 highest priority)
//   o_exc_type  out 32  one-hot exception_type for the highest set flag
//   o_sel_pc    out 1   bad address is the instruction PC (fetch-ADEL)
//   o_sel_addr  out 1   bad address is the load/store effective address
module exc_prio_enc
  import exc_dispatch_pkg::*;
(
  input  logic [7:0]  i_flags,
  output logic [31:0] o_exc_type,
  output logic        o_sel_pc,
  output logic        o_sel_addr
);

  always_comb begin
    o_exc_type = '0;
    o_sel_pc   = 1'b0;
    o_sel_addr = 1'b0;
    if (i_flags[FLG_FETCH_ADEL]) begin
      o_exc_type[EXC_FETCH_ADEL] = 1'b1;
      o_sel_pc                   = 1'b1;
    end else if (i_flags[FLG_RI]) begin
      o_exc_type[EXC_RI] = 1'b1;
    end else if (i_flags[FLG_OV]) begin
      o_exc_type[EXC_OV] = 1'b1;
    end else if (i_flags[FLG_BP]) begin
      o_exc_type[EXC_BP] = 1'b1;
    end else if (i_flags[FLG_SYS]) begin
      o_exc_type[EXC_SYS] = 1'b1;
    end else if (i_flags[FLG_LOAD_ADEL]) begin
      o_exc_type[EXC_LOAD_ADEL] = 1'b1;
      o_sel_addr                = 1'b1;
    end else if (i_flags[FLG_STORE_ADES]) begin
      o_exc_type[EXC_STORE_ADES] = 1'b1;
      o_sel_addr                 = 1'b1;
    end else if (i_flags[FLG_ERET]) begin
      o_exc_type[EXC_ERET] = 1'b1;
    end
  end

endmodule

// File: rtl/exc_dispatch.sv
// rtl/exc_dispatch.sv - MEM/WB exception dispatcher: CP0 request, flush, fetch redirect
// Ports:
//   clk, rst (async, active-low)
//   mem_valid_i/mem_pc_i/mem_addr_i/mem_is_branch_i/mem_excep_flags_i  MEM-stage instruction
//   kill_mem_o          combinational suppress of MEM side effects
//   exception_type_o, pc_o, exception_addr_o, now_in_delayslot_o  one-cycle CP0 request
//   cp0_flush_i, cp0_return_pc_i  CP0 answer
//   flush_pipe_o, redirect_valid_o, redirect_pc_o, redirect_ready_i  pipeline side
//   busy_o, drop_cnt_o  status
module exc_dispatch
  import exc_dispatch_pkg::*;
#(
  parameter int CP0_WAIT_MAX = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid_i,
  input  logic [31:0]      mem_pc_i,
  input  logic [31:0]      mem_addr_i,
  input  logic             mem_is_branch_i,
  input  logic [7:0]       mem_excep_flags_i,
  output logic             kill_mem_o,
  output logic [31:0]      exception_type_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      exception_addr_o,
  output logic             now_in_delayslot_o,
  input  logic             cp0_flush_i,
  input  logic [31:0]      cp0_return_pc_i,
  output logic             flush_pipe_o,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o,
  input  logic             redirect_ready_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  localparam int WCW = wait_cnt_width(CP0_WAIT_MAX);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(CP0_WAIT_MAX - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [WCW-1:0]   r_wait_cnt;
  logic [WCW-1:0]   w_wait_cnt_next;
  logic             w_drop;

  logic             w_issue_cond;
  logic             w_do_issue;
  logic [31:0]      w_exc_type;
  logic             w_sel_pc;
  logic             w_sel_addr;
  logic [31:0]      w_exc_addr;

  logic [31:0]      r_exc_type;
  logic [31:0]      r_pc;
  logic [31:0]      r_exc_addr;
  logic             r_in_ds;
  logic             r_ds;
  logic             r_flush_pipe;
  logic [31:0]      r_redirect_pc;
  logic [CNT_W-1:0] r_drop_cnt;

  exc_prio_enc u_prio_enc (
    .i_flags    (mem_excep_flags_i),
    .o_exc_type (w_exc_type),
    .o_sel_pc   (w_sel_pc),
    .o_sel_addr (w_sel_addr)
  );

  assign w_issue_cond = (r_state == ST_IDLE) && mem_valid_i && (mem_excep_flags_i != 8'd0);
  // A CP0 flush arriving alongside an issue wins; the instruction is still
  // killed because the flush throws it away anyway.
  assign w_do_issue   = w_issue_cond && !cp0_flush_i;
  assign kill_mem_o   = w_issue_cond;

  assign w_exc_addr = w_sel_pc   ? mem_pc_i   :
                      w_sel_addr ? mem_addr_i : 32'd0;

  assign redirect_valid_o   = (r_state == ST_REDIRECT);
  assign busy_o             = (r_state != ST_IDLE);
  assign exception_type_o   = r_exc_type;
  assign pc_o               = r_pc;
  assign exception_addr_o   = r_exc_addr;
  assign now_in_delayslot_o = r_in_ds;
  assign flush_pipe_o       = r_flush_pipe;
  assign redirect_pc_o      = r_redirect_pc;
  assign drop_cnt_o         = r_drop_cnt;

  always_comb begin
    w_next_state    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_drop          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cp0_flush_i) begin
          w_next_state = ST_REDIRECT;
        end else if (w_do_issue) begin
          w_next_state    = ST_WAIT_CP0;
          w_wait_cnt_next = '0;
        end
      end
      ST_WAIT_CP0: begin
        if (cp0_flush_i) begin
          w_next_state = ST_REDIRECT;
        end else if (r_wait_cnt == WAIT_LAST) begin
          // CP0 never answered (e.g. nested exception with EXL set)
          w_next_state = ST_IDLE;
          w_drop       = 1'b1;
        end else begin
          w_wait_cnt_next = r_wait_cnt + 1'b1;
        end
      end
      ST_REDIRECT: begin
        // A fresh flush re-targets the redirect and takes precedence over
        // a handshake completing in the same cycle.
        if (!cp0_flush_i && redirect_valid_o && redirect_ready_i) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_wait_cnt    <= '0;
      r_exc_type    <= '0;
      r_pc          <= '0;
      r_exc_addr    <= '0;
      r_in_ds       <= 1'b0;
      r_ds          <= 1'b0;
      r_flush_pipe  <= 1'b0;
      r_redirect_pc <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_next;

      // Request is present for exactly one cycle after the issue cycle
      r_exc_type <= w_do_issue ? w_exc_type : 32'd0;
      r_pc       <= w_do_issue ? mem_pc_i   : 32'd0;
      r_exc_addr <= w_do_issue ? w_exc_addr : 32'd0;
      r_in_ds    <= w_do_issue && r_ds;

      // Whatever sits in MEM during the flush pulse is discarded, so the
      // flush clear wins over a branch observed in the same cycle.
      if (r_flush_pipe) begin
        r_ds <= 1'b0;
      end else if (mem_valid_i) begin
        r_ds <= mem_is_branch_i;
      end

      r_flush_pipe <= cp0_flush_i;
      if (cp0_flush_i) begin
        r_redirect_pc <= cp0_return_pc_i;
      end

      if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_exc_dispatch.sv
// tb/tb_exc_dispatch.sv - self-checking bench for exc_dispatch
module tb_exc_dispatch;

  localparam int CP0_WAIT_MAX = 4;
  localparam int CNT_W        = 8;

  logic             clk;
  logic             rst;
  logic             mem_valid_i;
  logic [31:0]      mem_pc_i;
  logic [31:0]      mem_addr_i;
  logic             mem_is_branch_i;
  logic [7:0]       mem_excep_flags_i;
  logic             kill_mem_o;
  logic [31:0]      exception_type_o;
  logic [31:0]      pc_o;
  logic [31:0]      exception_addr_o;
  logic             now_in_delayslot_o;
  logic             cp0_flush_i;
  logic [31:0]      cp0_return_pc_i;
  logic             flush_pipe_o;
  logic             redirect_valid_o;
  logic [31:0]      redirect_pc_o;
  logic             redirect_ready_i;
  logic             busy_o;
  logic [CNT_W-1:0] drop_cnt_o;

  exc_dispatch #(.CP0_WAIT_MAX(CP0_WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .mem_valid_i        (mem_valid_i),
    .mem_pc_i           (mem_pc_i),
    .mem_addr_i         (mem_addr_i),
    .mem_is_branch_i    (mem_is_branch_i),
    .mem_excep_flags_i  (mem_excep_flags_i),
    .kill_mem_o         (kill_mem_o),
    .exception_type_o   (exception_type_o),
    .pc_o               (pc_o),
    .exception_addr_o   (exception_addr_o),
    .now_in_delayslot_o (now_in_delayslot_o),
    .cp0_flush_i        (cp0_flush_i),
    .cp0_return_pc_i    (cp0_return_pc_i),
    .flush_pipe_o       (flush_pipe_o),
    .redirect_valid_o   (redirect_valid_o),
    .redirect_pc_o      (redirect_pc_o),
    .redirect_ready_i   (redirect_ready_i),
    .busy_o             (busy_o),
    .drop_cnt_o         (drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: m_kind 0 = free, 1 = awaiting CP0, 2 = redirecting
  int          m_kind;
  int          m_age;
  bit          m_ds;
  logic [31:0] e_type, e_pc, e_addr, e_rpc;
  bit          e_ids, e_flush;
  int          e_drop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_kind = 0; m_age = 0; m_ds = 0;
    e_type = 0; e_pc = 0; e_addr = 0; e_rpc = 0;
    e_ids = 0; e_flush = 0; e_drop = 0;
  endtask

  // Highest set flag wins; flag bit i maps to cause bit 24+i, ERET to bit 0.
  // src: 0 no address, 1 instruction PC, 2 effective address
  function automatic void encode(input logic [7:0] f, output logic [31:0] t, output int src);
    t = 0;
    src = 0;
    for (int i = 7; i >= 0; i--) begin
      if (f[i]) begin
        t   = 32'd1 << ((i == 0) ? 0 : 24 + i);
        src = (i == 7) ? 1 : ((i == 2 || i == 1) ? 2 : 0);
        break;
      end
    end
  endfunction

  task automatic model_advance(input bit v, input logic [31:0] pc, input logic [31:0] addr,
                               input bit br, input logic [7:0] f, input bit fl,
                               input logic [31:0] rpc, input bit rdy);
    bit          issue;
    logic [31:0] t;
    int          src;
    issue = (m_kind == 0) && v && (f != 0) && !fl;
    encode(f, t, src);
    e_type = issue ? t : 32'd0;
    e_pc   = issue ? pc : 32'd0;
    e_addr = !issue ? 32'd0 : (src == 1) ? pc : (src == 2) ? addr : 32'd0;
    e_ids  = issue && m_ds;
    if (e_flush) m_ds = 0;
    else if (v)  m_ds = br;
    e_flush = fl;
    if (fl) begin
      e_rpc  = rpc;
      m_kind = 2;
    end else if (m_kind == 0) begin
      if (issue) begin
        m_kind = 1;
        m_age  = 0;
      end
    end else if (m_kind == 1) begin
      if (m_age == CP0_WAIT_MAX - 1) begin
        m_kind = 0;
        if (e_drop < (1 << CNT_W) - 1) e_drop++;
      end else begin
        m_age++;
      end
    end else if (rdy) begin
      m_kind = 0;
    end
  endtask

  task automatic check_outputs();
    chk("exc_type",    exception_type_o, e_type);
    chk("pc",          pc_o, e_pc);
    chk("exc_addr",    exception_addr_o, e_addr);
    chk("in_ds",       32'(now_in_delayslot_o), 32'(e_ids));
    chk("flush_pipe",  32'(flush_pipe_o), 32'(e_flush));
    chk("redir_valid", 32'(redirect_valid_o), 32'(m_kind == 2));
    chk("redir_pc",    redirect_pc_o, e_rpc);
    chk("busy",        32'(busy_o), 32'(m_kind != 0));
    chk("drop_cnt",    32'(drop_cnt_o), 32'(e_drop));
  endtask

  task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] addr,
                      input bit br, input logic [7:0] f, input bit fl,
                      input logic [31:0] rpc, input bit rdy);
    @(negedge clk);
    check_outputs();
    mem_valid_i       = v;
    mem_pc_i          = pc;
    mem_addr_i        = addr;
    mem_is_branch_i   = br;
    mem_excep_flags_i = f;
    cp0_flush_i       = fl;
    cp0_return_pc_i   = rpc;
    redirect_ready_i  = rdy;
    #1;
    chk("kill_mem", 32'(kill_mem_o), 32'((m_kind == 0) && v && (f != 0)));
    model_advance(v, pc, addr, br, f, fl, rpc, rdy);
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 0, 0, 8'h00, 0, 0, rdy);
  endtask

  task automatic zero_inputs();
    mem_valid_i = 0; mem_pc_i = 0; mem_addr_i = 0; mem_is_branch_i = 0;
    mem_excep_flags_i = 0; cp0_flush_i = 0; cp0_return_pc_i = 0; redirect_ready_i = 0;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    zero_inputs();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_exc_type",    exception_type_o, 32'd0);
    chk("rst_flush_pipe",  32'(flush_pipe_o), 32'd0);
    chk("rst_redir_valid", 32'(redirect_valid_o), 32'd0);
    chk("rst_redir_pc",    redirect_pc_o, 32'd0);
    chk("rst_busy",        32'(busy_o), 32'd0);
    chk("rst_kill",        32'(kill_mem_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic sample_after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          v, br, fl, rdy;
    logic [7:0]  f;
    zero_inputs();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    chk("reset_kill", 32'(kill_mem_o), 32'd0);
    rst = 1'b1;

    // OV issue, CP0 answers two cycles later, redirect held until ready
    step(1, 32'h8000_0100, 32'h0, 0, 8'h20, 0, 0, 0);
    sample_after_edge();
    chk("ov_type", exception_type_o, 32'h2000_0000);
    chk("ov_pc",   pc_o, 32'h8000_0100);
    idle(0);
    sample_after_edge();
    chk("ov_type_once", exception_type_o, 32'd0);
    step(0, 0, 0, 0, 8'h00, 1, 32'hbfc0_0380, 0);
    sample_after_edge();
    chk("ov_flush",      32'(flush_pipe_o), 32'd1);
    chk("ov_redir_pc",   redirect_pc_o, 32'hbfc0_0380);
    idle(0);
    sample_after_edge();
    chk("ov_flush_once", 32'(flush_pipe_o), 32'd0);
    chk("ov_redir_hold", redirect_pc_o, 32'hbfc0_0380);
    idle(1);
    sample_after_edge();
    chk("ov_done", 32'(busy_o), 32'd0);

    // Load-ADEL in a branch delay slot, then CP0 silence -> drop
    step(1, 32'h8000_0200, 32'h0, 1, 8'h00, 0, 0, 0);
    step(1, 32'h8000_0204, 32'h0000_0003, 0, 8'h04, 0, 0, 0);
    sample_after_edge();
    chk("ds_type", exception_type_o, 32'h0400_0000);
    chk("ds_addr", exception_addr_o, 32'h0000_0003);
    chk("ds_flag", 32'(now_in_delayslot_o), 32'd1);
    for (int i = 0; i < CP0_WAIT_MAX; i++) idle(0);
    sample_after_edge();
    chk("drop_idle",  32'(busy_o), 32'd0);
    chk("drop_cnt1",  32'(drop_cnt_o), 32'd1);
    chk("drop_noflush", 32'(flush_pipe_o), 32'd0);

    // RI + load-ADEL: only RI, no bad address
    step(1, 32'h8000_0300, 32'h0000_0011, 0, 8'h44, 0, 0, 0);
    sample_after_edge();
    chk("prio_type", exception_type_o, 32'h4000_0000);
    chk("prio_addr", exception_addr_o, 32'd0);
    idle(0);
    step(0, 0, 0, 0, 8'h00, 1, 32'hbfc0_0380, 1);
    idle(1);

    // Spontaneous flush (interrupt) with IF stalled three cycles
    step(0, 0, 0, 0, 8'h00, 1, 32'hbfc0_0380, 0);
    for (int i = 0; i < 3; i++) idle(0);
    idle(1);
    sample_after_edge();
    chk("intr_done", 32'(busy_o), 32'd0);

    // Reset while redirecting
    step(0, 0, 0, 0, 8'h00, 1, 32'h1234_5678, 0);
    idle(0);
    mid_reset();
    idle(0);
    sample_after_edge();
    chk("post_rst_busy", 32'(busy_o), 32'd0);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        mid_reset();
        continue;
      end
      v   = (m_kind == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2);
      br  = $urandom_range(0, 3) == 0;
      case ($urandom_range(0, 3))
        0, 1:    f = 8'h00;
        2:       f = 8'h01 << $urandom_range(0, 7);
        default: f = 8'($urandom);
      endcase
      case (m_kind)
        0:       fl = $urandom_range(0, 19) == 0;
        1:       fl = (m_age >= 1) && ($urandom_range(0, 3) == 0);
        default: fl = $urandom_range(0, 9) == 0;
      endcase
      rdy = $urandom_range(0, 1);
      step(v, $urandom, $urandom, br, f, fl, $urandom, rdy);
    end
    @(negedge clk);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
